// File: rtl/mismatch_monitor.sv
`timescale 1ns/1ps
// mismatch_monitor
//   Compares a reference vector against a value under test over a check
//   session and accumulates sample/error statistics.
//
//   A session is opened by start (from IDLE or DONE), runs until stop or
//   until TIMEOUT RUN cycles have elapsed, and then parks in DONE holding
//   its results until the next start.
//
// Parameters
//   WIDTH    width of q_ref / q_dut
//   CNT_W    width of all counters and captured sample indices
//   TIMEOUT  RUN-state cycle limit, 1 .. 2^CNT_W-1
//
// Ports
//   clk        rising-edge clock
//   areset_n   asynchronous active-low reset
//   start      open a new session (ignored while running)
//   stop       close the running session (ignored outside RUN)
//   sample_en  q_ref/q_dut hold a valid sample this cycle
//   q_ref      golden value
//   q_dut      value under test
//   busy       session running
//   done       session finished, results valid
//   pass       in DONE: no errors and no timeout
//   timeout    session ended by the cycle limit
//   samples    qualified samples seen (saturating)
//   errors     qualified samples that mismatched (saturating)
//   first_err  sample index of the first mismatch
//   mismatch   one-cycle flag following a mismatching sample
module mismatch_monitor #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] q_ref,
  input  logic [WIDTH-1:0] q_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic [CNT_W-1:0] first_err,
  output logic             mismatch
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cyc;

  logic             hit;
  logic             at_limit;
  logic [CNT_W-1:0] samples_inc;
  logic [CNT_W-1:0] errors_inc;
  logic [CNT_W-1:0] errors_after;

  always_comb begin
    hit          = 1'b0;
    at_limit     = 1'b0;
    samples_inc  = samples;
    errors_inc   = errors;
    errors_after = errors;

    hit      = sample_en && (q_ref != q_dut);
    at_limit = (cyc == CYC_LAST);

    if (samples != CNT_MAX) begin
      samples_inc = samples + CNT_W'(1);
    end
    if (errors != CNT_MAX) begin
      errors_inc = errors + CNT_W'(1);
    end
    // Error count as it will stand after this cycle, so a sample taken in
    // the same cycle as stop is reflected in pass.
    errors_after = hit ? errors_inc : errors;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= S_IDLE;
      cyc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      samples   <= '0;
      errors    <= '0;
      first_err <= '0;
      mismatch  <= 1'b0;
    end else begin
      mismatch <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            cyc       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            samples   <= '0;
            errors    <= '0;
            first_err <= '0;
          end
        end

        S_RUN: begin
          mismatch <= hit;

          if (sample_en) begin
            samples <= samples_inc;
          end

          if (hit) begin
            errors <= errors_inc;
            // errors saturates and never wraps back to zero, so zero here
            // means this is the session's first mismatch.
            if (errors == '0) begin
              first_err <= samples;
            end
          end

          // stop takes priority over the cycle limit in a coincident cycle.
          if (stop || at_limit) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= !stop;
            pass    <= stop && (errors_after == '0);
          end else begin
            cyc <= cyc + CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mismatch_monitor.sv
`timescale 1ns/1ps
module tb_mismatch_monitor;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       start;
  logic       stop;
  logic       sample_en;
  logic [7:0] q_ref;
  logic [7:0] q_dut;

  // Instance A: byte-wide, short timeout.
  logic        a_busy, a_done, a_pass, a_timeout, a_mismatch;
  logic [15:0] a_samples, a_errors, a_first_err;

  // Instance B: nibble-wide, 4-bit counters for saturation.
  logic        b_busy, b_done, b_pass, b_timeout, b_mismatch;
  logic [3:0]  b_samples, b_errors, b_first_err;

  int n_cmp = 0;
  int n_mis = 0;
  int pulses;

  always #5 clk = ~clk;

  mismatch_monitor #(
    .WIDTH   (8),
    .CNT_W   (16),
    .TIMEOUT (20)
  ) dut_a (
    .clk       (clk),
    .areset_n  (areset_n),
    .start     (start),
    .stop      (stop),
    .sample_en (sample_en),
    .q_ref     (q_ref),
    .q_dut     (q_dut),
    .busy      (a_busy),
    .done      (a_done),
    .pass      (a_pass),
    .timeout   (a_timeout),
    .samples   (a_samples),
    .errors    (a_errors),
    .first_err (a_first_err),
    .mismatch  (a_mismatch)
  );

  mismatch_monitor #(
    .WIDTH   (4),
    .CNT_W   (4),
    .TIMEOUT (15)
  ) dut_b (
    .clk       (clk),
    .areset_n  (areset_n),
    .start     (start),
    .stop      (stop),
    .sample_en (sample_en),
    .q_ref     (q_ref[3:0]),
    .q_dut     (q_dut[3:0]),
    .busy      (b_busy),
    .done      (b_done),
    .pass      (b_pass),
    .timeout   (b_timeout),
    .samples   (b_samples),
    .errors    (b_errors),
    .first_err (b_first_err),
    .mismatch  (b_mismatch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] r, input logic [7:0] d);
    sample_en = 1'b1;
    q_ref     = r;
    q_dut     = d;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] d;

    areset_n  = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    sample_en = 1'b0;
    q_ref     = '0;
    q_dut     = '0;

    // Reset state
    #12;
    chk("rst_busy",      a_busy,      0);
    chk("rst_done",      a_done,      0);
    chk("rst_pass",      a_pass,      0);
    chk("rst_timeout",   a_timeout,   0);
    chk("rst_samples",   a_samples,   0);
    chk("rst_errors",    a_errors,    0);
    chk("rst_first_err", a_first_err, 0);
    chk("rst_mismatch",  a_mismatch,  0);
    areset_n = 1'b1;

    // stop in IDLE is ignored
    do_stop();
    chk("idle_stop_busy", a_busy, 0);
    chk("idle_stop_done", a_done, 0);

    // 10 matching samples then stop
    do_start();
    chk("s1_busy",    a_busy,    1);
    chk("s1_samples", a_samples, 0);
    for (int i = 0; i < 10; i++) begin
      sample(8'(i), 8'(i));
    end
    chk("s1_mm_none", a_mismatch, 0);
    do_stop();
    chk("s1_done",      a_done,      1);
    chk("s1_busy0",     a_busy,      0);
    chk("s1_pass",      a_pass,      1);
    chk("s1_timeout",   a_timeout,   0);
    chk("s1_samples10", a_samples,   10);
    chk("s1_errors",    a_errors,    0);
    chk("s1_first_err", a_first_err, 0);
    // stop in DONE is ignored, results held
    do_stop();
    chk("s1_hold_done",    a_done,    1);
    chk("s1_hold_pass",    a_pass,    1);
    chk("s1_hold_samples", a_samples, 10);

    // 8 samples, mismatches at index 3 (msb only) and 6 (lsb only)
    do_start();
    chk("s2_busy",      a_busy,    1);
    chk("s2_clr_samp",  a_samples, 0);
    chk("s2_clr_pass",  a_pass,    0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      r = 8'(i * 3 + 1);
      d = (i == 3) ? (r ^ 8'h80) : (i == 6) ? (r ^ 8'h01) : r;
      sample(r, d);
      chk($sformatf("s2_mm%0d", i), a_mismatch, (i == 3 || i == 6) ? 1 : 0);
      if (a_mismatch) pulses++;
    end
    do_stop();
    chk("s2_done",      a_done,      1);
    chk("s2_samples",   a_samples,   8);
    chk("s2_errors",    a_errors,    2);
    chk("s2_first_err", a_first_err, 3);
    chk("s2_pass",      a_pass,      0);
    chk("s2_mm_after",  a_mismatch,  0);
    chk("s2_pulses",    pulses,      2);

    // Timeout after 20 RUN cycles with no stop
    do_start();
    repeat (19) tick();
    chk("to_busy19", a_busy, 1);
    chk("to_done19", a_done, 0);
    tick();
    chk("to_done",    a_done,    1);
    chk("to_busy",    a_busy,    0);
    chk("to_timeout", a_timeout, 1);
    chk("to_pass",    a_pass,    0);

    // stop on the terminal cycle beats the timeout
    do_start();
    chk("tos_clr_to", a_timeout, 0);
    repeat (19) tick();
    do_stop();
    chk("tos_done",    a_done,    1);
    chk("tos_timeout", a_timeout, 0);
    chk("tos_pass",    a_pass,    1);

    // start ignored in RUN; stop with a mismatching sample in same cycle
    do_start();
    sample(8'h11, 8'h11);
    start = 1'b1;
    sample(8'h22, 8'h22);
    start = 1'b0;
    chk("ss_samples2", a_samples, 2);
    chk("ss_busy",     a_busy,    1);
    stop = 1'b1;
    sample(8'h33, 8'h34);
    stop = 1'b0;
    chk("ss_done",      a_done,      1);
    chk("ss_samples",   a_samples,   3);
    chk("ss_errors",    a_errors,    1);
    chk("ss_first_err", a_first_err, 2);
    chk("ss_pass",      a_pass,      0);
    chk("ss_mismatch",  a_mismatch,  1);
    chk("ss_timeout",   a_timeout,   0);

    // Asynchronous reset mid-RUN
    do_start();
    sample(8'h01, 8'h01);
    sample(8'h02, 8'h03);
    sample(8'h04, 8'h04);
    chk("ar_errors_pre", a_errors, 1);
    chk("ar_busy_pre",   a_busy,   1);
    #1 areset_n = 1'b0;
    #1;
    chk("ar_busy",      a_busy,      0);
    chk("ar_done",      a_done,      0);
    chk("ar_samples",   a_samples,   0);
    chk("ar_errors",    a_errors,    0);
    chk("ar_first_err", a_first_err, 1 - 1);
    #1 areset_n = 1'b1;
    tick();
    chk("ar_idle_wait", a_busy, 0);
    do_start();
    chk("ar_busy_run",  a_busy,    1);
    chk("ar_samples0",  a_samples, 0);
    sample(8'h05, 8'h05);
    do_stop();
    chk("ar_samples1",  a_samples, 1);
    chk("ar_errors1",   a_errors,  0);
    chk("ar_pass",      a_pass,    1);

    // Saturation with 4-bit counters: 20 mismatching samples offered
    do_start();
    for (int i = 0; i < 20; i++) begin
      sample(8'h05, 8'h0A);
    end
    chk("sat_b_done",      b_done,      1);
    chk("sat_b_timeout",   b_timeout,   1);
    chk("sat_b_samples",   b_samples,   15);
    chk("sat_b_errors",    b_errors,    15);
    chk("sat_b_first_err", b_first_err, 0);
    chk("sat_b_pass",      b_pass,      0);
    chk("sat_b_mm_done",   b_mismatch,  0);
    chk("sat_a_samples",   a_samples,   20);
    chk("sat_a_errors",    a_errors,    20);
    chk("sat_a_timeout",   a_timeout,   1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
